// File: rtl/serdes_pkg.sv
// Shared definitions for the serializer/deserializer pair: default word
// geometry and the two-state framing FSM encoding.
package serdes_pkg;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_LOG_WIDTH = 3;

    // Framing FSM encoding, kept as plain constants so older tools and
    // the serializer can share the same values.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage : serdes_pkg

// File: rtl/deser_fifo2.sv
// Two-entry output buffer. The oldest word is always held in head_q, so the
// read data is a flop output and reads as zero whenever the buffer is empty.
module deser_fifo2
    import serdes_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       cnt_q,  cnt_d;
    logic             pop_s;
    logic             push_s;

    // Next-state of the two slots; a pop on the same edge frees room for a push.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        pop_s  = pop && (cnt_q != 2'd0);
        push_s = push && ((cnt_q != 2'd2) || pop_s);
        case ({push_s, pop_s})
            2'b10: begin
                case (cnt_q)
                    2'd0: begin
                        head_d = din;
                        cnt_d  = 2'd1;
                    end
                    2'd1: begin
                        tail_d = din;
                        cnt_d  = 2'd2;
                    end
                    default: begin
                        cnt_d = cnt_q;
                    end
                endcase
            end
            2'b01: begin
                case (cnt_q)
                    2'd1: begin
                        head_d = {WIDTH{1'b0}};
                        cnt_d  = 2'd0;
                    end
                    2'd2: begin
                        head_d = tail_q;
                        tail_d = {WIDTH{1'b0}};
                        cnt_d  = 2'd1;
                    end
                    default: begin
                        cnt_d = cnt_q;
                    end
                endcase
            end
            2'b11: begin
                // Occupancy is unchanged; the word moves through the slots.
                if (cnt_q == 2'd1) begin
                    head_d = din;
                end else begin
                    head_d = tail_q;
                    tail_d = din;
                end
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Slot and occupancy registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= {WIDTH{1'b0}};
            tail_q <= {WIDTH{1'b0}};
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout  = head_q;
    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);

endmodule : deser_fifo2

// File: rtl/deserializer.sv
// Serial-to-parallel converter: LSB-first bits framed by sync_start are
// assembled into WIDTH-bit words and queued in a two-entry output buffer.
module deserializer
    import serdes_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int LOG_WIDTH = DEFAULT_LOG_WIDTH
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sync_start,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    input  logic             clr_overflow,
    output logic             overflow,
    output logic             frame_err
);

    localparam logic [LOG_WIDTH:0] CNT_ONE  = {{LOG_WIDTH{1'b0}}, 1'b1};
    localparam logic [LOG_WIDTH:0] LAST_IDX = (LOG_WIDTH + 1)'(WIDTH - 1);

    logic [0:0]       state_q,     state_d;
    logic [LOG_WIDTH:0] count_q,   count_d;
    logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q,  overflow_d;
    logic             push_s;
    logic [WIDTH-1:0] word_s;
    logic             full_s;
    logic             empty_s;

    // Completed word: the bit arriving now becomes the MSB.
    assign word_s = {sin, shift_reg_q[WIDTH-2:0]};

    // Framing FSM and bit assembly; only qualified bits advance anything.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        shift_reg_d = shift_reg_q;
        frame_err_d = 1'b0;
        push_s      = 1'b0;
        if (sin_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (sync_start) begin
                        shift_reg_d    = {WIDTH{1'b0}};
                        shift_reg_d[0] = sin;
                        count_d        = CNT_ONE;
                        state_d        = ST_SHIFT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (sync_start) begin
                        // Restart mid-word: drop the partial word and flag it.
                        frame_err_d    = 1'b1;
                        shift_reg_d    = {WIDTH{1'b0}};
                        shift_reg_d[0] = sin;
                        count_d        = CNT_ONE;
                    end else if (count_q == LAST_IDX) begin
                        push_s      = 1'b1;
                        shift_reg_d = {WIDTH{1'b0}};
                        count_d     = {(LOG_WIDTH + 1){1'b0}};
                        state_d     = ST_IDLE;
                    end else begin
                        shift_reg_d[count_q[LOG_WIDTH-1:0]] = sin;
                        count_d = count_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    count_d     = {(LOG_WIDTH + 1){1'b0}};
                    shift_reg_d = {WIDTH{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Sticky drop flag: a drop on the same edge as a clear wins.
    always_comb begin
        if (push_s && full_s && !dout_ready) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Framing state, assembly register and status flags.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            count_q     <= {(LOG_WIDTH + 1){1'b0}};
            shift_reg_q <= {WIDTH{1'b0}};
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_reg_q <= shift_reg_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    deser_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .push     (push_s),
        .din      (word_s),
        .pop      (dout_ready),
        .dout     (dout),
        .full     (full_s),
        .empty    (empty_s)
    );

    assign dout_valid = !empty_s;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

endmodule : deserializer

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning parallel word width in bits.
REQ-002 SHALL have parameter LOG_WIDTH, default 3, meaning log2(WIDTH); the bit counter is LOG_WIDTH+1 bits wide.
REQ-003 SHALL have port clock_in  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sin  input  1  serial data bit, LSB of each word first.
REQ-006 SHALL have port sin_valid  input  1  qualifies sin on the current edge; when low the bit is ignored.
REQ-007 SHALL have port sync_start  input  1  marks the qualified bit as bit 0 of a new word; meaningful only with sin_valid=1.
REQ-008 SHALL have port dout  output  WIDTH  parallel word at the head of the output buffer.
REQ-009 SHALL have port dout_valid  output  1  dout holds an unconsumed word.
REQ-010 SHALL have port dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready at a rising edge.
REQ-011 SHALL have port clr_overflow  input  1  synchronous clear of the overflow flag.
REQ-012 SHALL have port overflow  output  1  sticky flag: a completed word was dropped.
REQ-013 SHALL have port frame_err  output  1  one-cycle pulse: a word was restarted before completion.

Function
REQ-014 SHALL implement FSM states IDLE and SHIFT; IDLE ignores qualified bits without sync_start.
REQ-015 SHALL, in IDLE on sin_valid && sync_start, store sin into shift_reg[0], set count=1 and go to SHIFT.
REQ-016 SHALL, in SHIFT on sin_valid && !sync_start, store sin into shift_reg[count] and increment count.
REQ-017 SHALL hold count and shift_reg unchanged on any edge with sin_valid=0, in both states.
REQ-018 SHALL, when the qualified bit is bit WIDTH-1, push {sin, shift_reg[WIDTH-2:0]} into the output buffer and return to IDLE with count=0.
REQ-019 SHALL, on sync_start with sin_valid in SHIFT, discard the partial word, pulse frame_err for one cycle, store sin as bit 0 and set count=1, remaining in SHIFT.
REQ-020 SHALL provide a 2-entry FIFO output buffer; dout_valid = buffer not empty; dout = oldest entry.
REQ-021 SHALL make a completed word visible on dout/dout_valid the cycle after the edge that captured its last bit when the buffer was empty (latency 1 clock from last bit).
REQ-022 SHALL, when a push occurs with the buffer full and no pop on the same edge, drop the new word and set overflow to 1.
REQ-023 SHALL, when push and pop coincide with the buffer full, accept the push (pop frees the slot) and leave overflow unchanged.
REQ-024 SHALL keep overflow set until clr_overflow=1; if clr_overflow and a new drop coincide, overflow SHALL be 1.
REQ-025 SHALL keep dout stable while dout_valid=1 and dout_ready=0.
REQ-026 SHALL drive dout to 0 when the buffer is empty.

Reset
REQ-027 SHALL, on reset_n low, immediately force: state=IDLE, count=0, shift_reg=0, buffer empty, dout=0, dout_valid=0, overflow=0, frame_err=0.
REQ-028 SHALL discard any partial word and all buffered words when reset asserts mid-operation; first word after release requires a new sync_start.

Structure
REQ-029 SHALL place the FSM state encoding (IDLE, SHIFT) and the WIDTH/LOG_WIDTH defaults in shared package serdes_pkg, used by serializer and deserializer alike.
REQ-030 SHALL implement the output buffer as sub-module deser_fifo2 (parameter WIDTH; push/pop/full/empty, async active-low reset).

Verification
REQ-031 SHALL cover: sync_start on bit 0, 8 consecutive valid bits 0,1,0,0,1,1,0,1 (LSB first), dout_ready=1 -> dout=8'hB2, dout_valid high exactly one cycle, one cycle after last bit.
REQ-032 SHALL cover: same word with sin_valid deasserted for 3 cycles between bits 3 and 4 -> dout=8'hB2, no frame_err.
REQ-033 SHALL cover: sync_start reasserted at bit 5 of a word, then 8 bits of 8'h5A -> frame_err single pulse, only 8'h5A delivered.
REQ-034 SHALL cover: dout_ready=0, three words 8'h11, 8'h22, 8'h33 -> buffer holds 11,22; overflow=1; raising dout_ready delivers 11 then 22; clr_overflow clears the flag.
REQ-035 SHALL cover: dout_ready=0, buffer full, pop and third-word push on the same edge -> no overflow; words 11,22,33 delivered in order.
REQ-036 SHALL cover: reset_n pulsed low at bit 4 with one word buffered -> all outputs 0 immediately; a subsequent full word decodes correctly.
